// File: rtl/sms_vdp_pkg.sv
// rtl/sms_vdp_pkg.sv - shared encodings for the line pixel mixer
package sms_vdp_pkg;

    typedef enum logic [1:0] {
        SRC_BACKDROP = 2'd0,
        SRC_BG       = 2'd1,
        SRC_SPR      = 2'd2,
        SRC_MASK     = 2'd3
    } pix_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mix_state_e;

endpackage

// File: rtl/line_buffer_pair.sv
// rtl/line_buffer_pair.sv - shadow/active line storage with promotion and a column read port
module line_buffer_pair #(
    parameter int LINE_W = 256,
    parameter int PLANES = 4,
    localparam int CW    = $clog2(LINE_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic                     promote,
    input  logic [PLANES*LINE_W-1:0] load_spr,
    input  logic [LINE_W-1:0]        load_spr_en,
    input  logic [PLANES*LINE_W-1:0] load_bg,
    input  logic [LINE_W-1:0]        load_bg_en,
    input  logic [LINE_W-1:0]        load_bg_pri,
    input  logic [LINE_W-1:0]        load_bg_pal,
    input  logic                     load_mask,
    output logic                     shadow_full,
    input  logic                     rd_shadow,
    input  logic [CW-1:0]            rd_col,
    output logic [PLANES-1:0]        rd_spr,
    output logic                     rd_spr_en,
    output logic [PLANES-1:0]        rd_bg,
    output logic                     rd_bg_en,
    output logic                     rd_bg_pri,
    output logic                     rd_bg_pal,
    output logic                     rd_mask
);

    localparam int IDXW = $clog2(PLANES*LINE_W);

    logic [PLANES*LINE_W-1:0] sh_spr, sh_bg, ac_spr, ac_bg, spr_sel, bg_sel;
    logic [LINE_W-1:0]        sh_spr_en, sh_bg_en, sh_bg_pri, sh_bg_pal;
    logic [LINE_W-1:0]        ac_spr_en, ac_bg_en, ac_bg_pri, ac_bg_pal;
    logic [LINE_W-1:0]        spr_en_sel, bg_en_sel, bg_pri_sel, bg_pal_sel;
    logic                     sh_mask, ac_mask;

    // Load only happens while shadow is empty and promotion only while it is full,
    // so the two never collide on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_full <= 1'b0;
            sh_spr      <= '0;
            sh_bg       <= '0;
            sh_spr_en   <= '0;
            sh_bg_en    <= '0;
            sh_bg_pri   <= '0;
            sh_bg_pal   <= '0;
            sh_mask     <= 1'b0;
            ac_spr      <= '0;
            ac_bg       <= '0;
            ac_spr_en   <= '0;
            ac_bg_en    <= '0;
            ac_bg_pri   <= '0;
            ac_bg_pal   <= '0;
            ac_mask     <= 1'b0;
        end else begin
            if (load_en) begin
                shadow_full <= 1'b1;
                sh_spr      <= load_spr;
                sh_bg       <= load_bg;
                sh_spr_en   <= load_spr_en;
                sh_bg_en    <= load_bg_en;
                sh_bg_pri   <= load_bg_pri;
                sh_bg_pal   <= load_bg_pal;
                sh_mask     <= load_mask;
            end
            if (promote) begin
                shadow_full <= 1'b0;
                ac_spr      <= sh_spr;
                ac_bg       <= sh_bg;
                ac_spr_en   <= sh_spr_en;
                ac_bg_en    <= sh_bg_en;
                ac_bg_pri   <= sh_bg_pri;
                ac_bg_pal   <= sh_bg_pal;
                ac_mask     <= sh_mask;
            end
        end
    end

    // Reading shadow lets the mixer register column 0 on the promotion edge itself.
    always_comb begin
        spr_sel    = rd_shadow ? sh_spr    : ac_spr;
        bg_sel     = rd_shadow ? sh_bg     : ac_bg;
        spr_en_sel = rd_shadow ? sh_spr_en : ac_spr_en;
        bg_en_sel  = rd_shadow ? sh_bg_en  : ac_bg_en;
        bg_pri_sel = rd_shadow ? sh_bg_pri : ac_bg_pri;
        bg_pal_sel = rd_shadow ? sh_bg_pal : ac_bg_pal;
        rd_mask    = rd_shadow ? sh_mask   : ac_mask;
        rd_spr     = '0;
        rd_bg      = '0;
        for (int p = 0; p < PLANES; p++) begin
            rd_spr[p] = spr_sel[IDXW'(p * LINE_W) + IDXW'(rd_col)];
            rd_bg[p]  = bg_sel[IDXW'(p * LINE_W) + IDXW'(rd_col)];
        end
        rd_spr_en = spr_en_sel[rd_col];
        rd_bg_en  = bg_en_sel[rd_col];
        rd_bg_pri = bg_pri_sel[rd_col];
        rd_bg_pal = bg_pal_sel[rd_col];
    end

endmodule

// File: rtl/line_pixel_mixer.sv
// rtl/line_pixel_mixer.sv - double-buffered sprite/background line mixer streaming palette addresses
module line_pixel_mixer
    import sms_vdp_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int PLANES = 4,
    parameter int MASK_W = 8,
    localparam int CW    = $clog2(LINE_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [PLANES*LINE_W-1:0] load_spr,
    input  logic [LINE_W-1:0]        load_spr_en,
    input  logic [PLANES*LINE_W-1:0] load_bg,
    input  logic [LINE_W-1:0]        load_bg_en,
    input  logic [LINE_W-1:0]        load_bg_pri,
    input  logic [LINE_W-1:0]        load_bg_pal,
    input  logic [PLANES-1:0]        backdrop,
    input  logic                     mask_left,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [PLANES:0]          pix_addr,
    output logic [CW-1:0]            pix_col,
    output logic [1:0]               pix_src,
    output logic                     pix_last,
    output logic                     line_done
);

    mix_state_e        state, state_nxt;
    pix_src_e          src_q, mix_src;
    logic [PLANES:0]   mix_addr;
    logic [CW-1:0]     rd_col;
    logic [PLANES-1:0] rd_spr, rd_bg;
    logic              rd_spr_en, rd_bg_en, rd_bg_pri, rd_bg_pal, rd_mask;
    logic              shadow_full, promote, advance, accept_last, last_col;

    assign load_ready = !shadow_full;
    assign pix_valid  = (state == ST_RUN);
    assign pix_src    = src_q;
    assign last_col   = (pix_col == CW'(LINE_W - 1));

    line_buffer_pair #(
        .LINE_W (LINE_W),
        .PLANES (PLANES)
    ) u_bufs (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_valid && load_ready),
        .promote     (promote),
        .load_spr    (load_spr),
        .load_spr_en (load_spr_en),
        .load_bg     (load_bg),
        .load_bg_en  (load_bg_en),
        .load_bg_pri (load_bg_pri),
        .load_bg_pal (load_bg_pal),
        .load_mask   (mask_left),
        .shadow_full (shadow_full),
        .rd_shadow   (promote),
        .rd_col      (rd_col),
        .rd_spr      (rd_spr),
        .rd_spr_en   (rd_spr_en),
        .rd_bg       (rd_bg),
        .rd_bg_en    (rd_bg_en),
        .rd_bg_pri   (rd_bg_pri),
        .rd_bg_pal   (rd_bg_pal),
        .rd_mask     (rd_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        promote     = 1'b0;
        advance     = 1'b0;
        accept_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (shadow_full) begin
                    promote   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pix_ready) begin
                    if (last_col) begin
                        accept_last = 1'b1;
                        if (shadow_full) promote   = 1'b1;
                        else             state_nxt = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mix the column that will be presented after this edge.
    always_comb begin
        rd_col   = promote ? '0 : pix_col + 1'b1;
        mix_addr = {1'b1, backdrop};
        mix_src  = SRC_BACKDROP;
        if (rd_mask && (rd_col < CW'(MASK_W))) begin
            mix_src = SRC_MASK;
        end else if (rd_bg_en && rd_bg_pri) begin
            mix_addr = {rd_bg_pal, rd_bg};
            mix_src  = SRC_BG;
        end else if (rd_spr_en) begin
            mix_addr = {1'b1, rd_spr};
            mix_src  = SRC_SPR;
        end else if (rd_bg_en) begin
            mix_addr = {rd_bg_pal, rd_bg};
            mix_src  = SRC_BG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_col   <= '0;
            pix_addr  <= '0;
            src_q     <= SRC_BACKDROP;
            pix_last  <= 1'b0;
            line_done <= 1'b0;
        end else begin
            line_done <= accept_last;
            if (promote || advance) begin
                pix_col  <= rd_col;
                pix_addr <= mix_addr;
                src_q    <= mix_src;
                pix_last <= (rd_col == CW'(LINE_W - 1));
            end else if (state_nxt == ST_IDLE) begin
                pix_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_pixel_mixer.sv
// tb/tb_line_pixel_mixer.sv - scoreboard bench for line_pixel_mixer
module tb_line_pixel_mixer;

    localparam int LW = 256;
    localparam int PL = 4;
    localparam int MW = 8;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [PL*LW-1:0] load_spr = '0;
    logic [PL*LW-1:0] load_bg = '0;
    logic [LW-1:0]  load_spr_en = '0;
    logic [LW-1:0]  load_bg_en = '0;
    logic [LW-1:0]  load_bg_pri = '0;
    logic [LW-1:0]  load_bg_pal = '0;
    logic [PL-1:0]  backdrop = '0;
    logic           mask_left = 1'b0;
    logic           pix_valid;
    logic           pix_ready = 1'b0;
    logic [PL:0]    pix_addr;
    logic [CW-1:0]  pix_col;
    logic [1:0]     pix_src;
    logic           pix_last;
    logic           line_done;

    typedef struct packed {
        logic [PL:0]   addr;
        logic [1:0]    src;
        logic [CW-1:0] col;
        logic          last;
    } pix_t;

    pix_t        exp_q[$];
    logic [PL-1:0] spr_a[LW];
    logic [PL-1:0] bg_a[LW];
    logic        spr_en_a[LW];
    logic        bg_en_a[LW];
    logic        bg_pri_a[LW];
    logic        bg_pal_a[LW];
    int          vectors = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic        ld_next = 1'b0;

    line_pixel_mixer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_spr    (load_spr),
        .load_spr_en (load_spr_en),
        .load_bg     (load_bg),
        .load_bg_en  (load_bg_en),
        .load_bg_pri (load_bg_pri),
        .load_bg_pal (load_bg_pal),
        .backdrop    (backdrop),
        .mask_left   (mask_left),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_addr    (pix_addr),
        .pix_col     (pix_col),
        .pix_src     (pix_src),
        .pix_last    (pix_last),
        .line_done   (line_done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        pix_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    task automatic rand_line(input bit enables);
        for (int c = 0; c < LW; c++) begin
            spr_a[c]    = 4'($urandom_range(0, 15));
            bg_a[c]     = 4'($urandom_range(0, 15));
            spr_en_a[c] = enables ? 1'($urandom_range(0, 1)) : 1'b0;
            bg_en_a[c]  = enables ? 1'($urandom_range(0, 1)) : 1'b0;
            bg_pri_a[c] = enables ? 1'($urandom_range(0, 1)) : 1'b0;
            bg_pal_a[c] = enables ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    // Drives the load buses from the column arrays and queues the pixels the line must produce.
    task automatic stage_line();
        pix_t e;
        for (int c = 0; c < LW; c++) begin
            for (int p = 0; p < PL; p++) begin
                load_spr[p*LW+c] = spr_a[c][p];
                load_bg[p*LW+c]  = bg_a[c][p];
            end
            load_spr_en[c] = spr_en_a[c];
            load_bg_en[c]  = bg_en_a[c];
            load_bg_pri[c] = bg_pri_a[c];
            load_bg_pal[c] = bg_pal_a[c];
            e.col  = CW'(c);
            e.last = (c == LW - 1);
            if (mask_left && c < MW) begin
                e.addr = {1'b1, backdrop}; e.src = 2'd3;
            end else if (bg_en_a[c] && bg_pri_a[c]) begin
                e.addr = {bg_pal_a[c], bg_a[c]}; e.src = 2'd1;
            end else if (spr_en_a[c]) begin
                e.addr = {1'b1, spr_a[c]}; e.src = 2'd2;
            end else if (bg_en_a[c]) begin
                e.addr = {bg_pal_a[c], bg_a[c]}; e.src = 2'd1;
            end else begin
                e.addr = {1'b1, backdrop}; e.src = 2'd0;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_load();
        int t = 0;
        @(posedge clk);
        #1;
        while (!load_ready && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!load_ready) begin
            timeout_fail("load_handshake");
        end else begin
            stage_line();
            load_valid = 1'b1;
            @(posedge clk);
            #1;
            load_valid = 1'b0;
        end
    endtask

    task automatic wait_col(input int c);
        int t = 0;
        @(negedge clk);
        while (!(pix_valid && pix_col == CW'(c)) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!(pix_valid && pix_col == CW'(c))) timeout_fail($sformatf("wait_col_%0d", c));
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || pix_valid) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || pix_valid) begin
            timeout_fail("wait_idle");
            exp_q.delete();
        end
    endtask

    // Monitor: compares every presented pixel with the scoreboard head, pops on acceptance.
    always @(negedge clk) begin
        pix_t e;
        if (rst_n) begin
            chk("line_done", 32'(line_done), 32'(ld_next));
            ld_next = 1'b0;
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    timeout_fail($sformatf("unexpected_pixel_col_%0d", pix_col));
                end else begin
                    e = exp_q[0];
                    chk($sformatf("pix_addr@%0d", e.col), 32'(pix_addr), 32'(e.addr));
                    chk($sformatf("pix_src@%0d", e.col), 32'(pix_src), 32'(e.src));
                    chk($sformatf("pix_col@%0d", e.col), 32'(pix_col), 32'(e.col));
                    chk($sformatf("pix_last@%0d", e.col), 32'(pix_last), 32'(e.last));
                    if (pix_ready) begin
                        void'(exp_q.pop_front());
                        if (e.last) ld_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_col", 32'(pix_col), 32'd0);
        chk("rst_pix_addr", 32'(pix_addr), 32'd0);
        chk("rst_pix_src", 32'(pix_src), 32'd0);
        chk("rst_pix_last", 32'(pix_last), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain backdrop line
        ready_mode = 0;
        backdrop = 4'h5;
        mask_left = 1'b0;
        rand_line(1'b0);
        do_load();
        wait_col(0);
        chk("backdrop_addr", 32'(pix_addr), 32'h15);
        wait_idle();

        // Sprite over low-priority background, then priority background
        rand_line(1'b1);
        spr_en_a[10] = 1'b1; spr_a[10] = 4'h3;
        bg_en_a[10] = 1'b1; bg_pri_a[10] = 1'b0; bg_pal_a[10] = 1'b0; bg_a[10] = 4'h9;
        do_load();
        wait_col(10);
        chk("spr_over_bg_addr", 32'(pix_addr), 32'h13);
        chk("spr_over_bg_src", 32'(pix_src), 32'd2);
        wait_idle();
        bg_pri_a[10] = 1'b1;
        do_load();
        wait_col(10);
        chk("bg_pri_addr", 32'(pix_addr), 32'h09);
        chk("bg_pri_src", 32'(pix_src), 32'd1);
        wait_idle();

        // Left-column masking
        mask_left = 1'b1;
        for (int c = 0; c < LW; c++) begin
            bg_en_a[c] = 1'b1; bg_a[c] = 4'hA; bg_pal_a[c] = 1'b0;
            bg_pri_a[c] = 1'b0; spr_en_a[c] = 1'b0;
        end
        do_load();
        wait_col(7);
        chk("mask_col7_addr", 32'(pix_addr), 32'h15);
        chk("mask_col7_src", 32'(pix_src), 32'd3);
        wait_col(8);
        chk("mask_col8_addr", 32'(pix_addr), 32'h0A);
        wait_idle();
        mask_left = 1'b0;

        // Back-to-back lines with no bubble
        rand_line(1'b1);
        do_load();
        rand_line(1'b1);
        do_load();
        @(negedge clk);
        chk("shadow_held_ready", 32'(load_ready), 32'd0);
        wait_col(255);
        chk("pre_promote_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        chk("no_bubble_valid", 32'(pix_valid), 32'd1);
        chk("no_bubble_col", 32'(pix_col), 32'd0);
        chk("post_promote_ready", 32'(load_ready), 32'd1);
        wait_idle();

        // Load landing on the last-pixel edge gives exactly one bubble
        rand_line(1'b1);
        do_load();
        wait_col(255);
        chk("coincide_ready", 32'(load_ready), 32'd1);
        rand_line(1'b1);
        stage_line();
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(negedge clk);
        chk("bubble_valid", 32'(pix_valid), 32'd0);
        @(negedge clk);
        chk("after_bubble_valid", 32'(pix_valid), 32'd1);
        chk("after_bubble_col", 32'(pix_col), 32'd0);
        wait_idle();

        // Random backpressure, random content
        ready_mode = 1;
        for (int b = 0; b < 2; b++) begin
            backdrop = 4'($urandom_range(0, 15));
            for (int l = 0; l < 3; l++) begin
                mask_left = 1'($urandom_range(0, 1));
                rand_line(1'b1);
                do_load();
            end
            wait_idle();
        end
        mask_left = 1'b0;

        // Reset in the middle of a line with the shadow full
        ready_mode = 0;
        rand_line(1'b1);
        do_load();
        rand_line(1'b1);
        do_load();
        wait_col(100);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        ld_next = 1'b0;
        #1;
        chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
        chk("midrst_pix_col", 32'(pix_col), 32'd0);
        chk("midrst_pix_addr", 32'(pix_addr), 32'd0);
        chk("midrst_pix_src", 32'(pix_src), 32'd0);
        chk("midrst_pix_last", 32'(pix_last), 32'd0);
        chk("midrst_line_done", 32'(line_done), 32'd0);
        chk("midrst_load_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("postrst_idle_%0d", i), 32'(pix_valid), 32'd0);
        end
        rand_line(1'b1);
        do_load();
        wait_idle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
